// File: rtl/arm_pkg.sv
// Shared ARMv4 datapath definitions: condition codes, NZCV bit positions and
// the FlagW encoding used between decoder, ALU and the conditional unit.
package arm_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagW bit positions and full encodings
  localparam int FLAGW_NZ_BIT = 1;
  localparam int FLAGW_CV_BIT = 0;

  localparam logic [1:0] FLAGW_NONE = 2'b00;
  localparam logic [1:0] FLAGW_CV   = 2'b01;
  localparam logic [1:0] FLAGW_NZ   = 2'b10;
  localparam logic [1:0] FLAGW_ALL  = 2'b11;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: (condition field, NZCV) -> pass/fail.
// Kept standalone so the branch-predictor checker can share it.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_cond_ex
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  logic w_ge;

  assign w_n  = i_flags[FLAG_N];
  assign w_z  = i_flags[FLAG_Z];
  assign w_c  = i_flags[FLAG_C];
  assign w_v  = i_flags[FLAG_V];
  assign w_ge = (w_n == w_v);

  always_comb begin
    o_cond_ex = 1'b0;
    case (cond_e'(i_cond))
      COND_EQ: o_cond_ex = w_z;
      COND_NE: o_cond_ex = ~w_z;
      COND_CS: o_cond_ex = w_c;
      COND_CC: o_cond_ex = ~w_c;
      COND_MI: o_cond_ex = w_n;
      COND_PL: o_cond_ex = ~w_n;
      COND_VS: o_cond_ex = w_v;
      COND_VC: o_cond_ex = ~w_v;
      COND_HI: o_cond_ex = w_c & ~w_z;
      COND_LS: o_cond_ex = ~w_c | w_z;
      COND_GE: o_cond_ex = w_ge;
      COND_LT: o_cond_ex = ~w_ge;
      COND_GT: o_cond_ex = ~w_z & w_ge;
      COND_LE: o_cond_ex = w_z | ~w_ge;
      COND_AL: o_cond_ex = 1'b1;
      COND_NV: o_cond_ex = 1'b0;
      default: o_cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds architectural NZCV, gates write enables
// on the condition result and counts condition-failed instructions.
module cond_unit
  import arm_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             stall,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             clr_count,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] skip_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_skip_cnt;

  logic w_cond_ex;
  logic w_step;
  logic w_upd;
  logic w_skip;
  logic w_cnt_max;

  // Decode sees only the registered flags; no forwarding of ALUFlags.
  cond_check u_cond_check (
    .i_cond    (Cond),
    .i_flags   (r_flags),
    .o_cond_ex (w_cond_ex)
  );

  assign w_step    = valid & ~stall;
  assign w_upd     = w_step & w_cond_ex;
  assign w_skip    = w_step & ~w_cond_ex;
  assign w_cnt_max = &r_skip_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= RESET_FLAGS;
    end else begin
      if (w_upd & FlagW[FLAGW_NZ_BIT]) begin
        r_flags[FLAG_N] <= ALUFlags[FLAG_N];
        r_flags[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (w_upd & FlagW[FLAGW_CV_BIT]) begin
        r_flags[FLAG_C] <= ALUFlags[FLAG_C];
        r_flags[FLAG_V] <= ALUFlags[FLAG_V];
      end
    end
  end

  // Saturating skip counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_skip_cnt <= '0;
    end else if (clr_count) begin
      r_skip_cnt <= '0;
    end else if (w_skip && !w_cnt_max) begin
      r_skip_cnt <= r_skip_cnt + CNT_ONE;
    end
  end

  // Enables are deliberately not qualified by valid/stall.
  assign CondEx     = w_cond_ex;
  assign PCSrc      = PCS & w_cond_ex;
  assign RegWrite   = RegW & w_cond_ex & ~NoWrite;
  assign MemWrite   = MemW & w_cond_ex;
  assign Flags      = r_flags;
  assign skip_count = r_skip_cnt;

endmodule
